// File: rtl/cve2_obi_mem_responder.sv
// rtl/cve2_obi_mem_responder.sv - OBI-style memory responder with grant wait states, response latency and error injection
module cve2_obi_mem_responder #(
   parameter int          MemWords    = 1024,
   parameter logic [31:0] BaseAddr    = 32'h0000_0000,
   parameter int          GntDelay    = 0,
   parameter int          RespLatency = 1,
   parameter logic [31:0] ErrAddr     = 32'hFFFF_FFFC
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   input  logic        stall_i
);

   localparam int AW   = $clog2(MemWords);
   localparam int CntW = (GntDelay > 1) ? $clog2(GntDelay) : 1;
   localparam logic [CntW-1:0] CntInit = CntW'((GntDelay > 0) ? GntDelay - 1 : 0);

   typedef enum logic {IDLE, WAIT} state_e;

   state_e          state_q;
   logic [CntW-1:0] cnt_q;

   logic [31:0]     mem_q [MemWords];

   logic            valid_q [RespLatency];
   logic            err_q   [RespLatency];
   logic [31:0]     rdata_q [RespLatency];

   logic [AW-1:0]   idx;
   logic            in_range;
   logic            unused_addr;

   // BaseAddr is aligned to the RAM size, so the range check reduces to an
   // upper-bit match; the injected error word is excluded on top of that.
   assign idx         = addr_i[AW+1:2];
   assign in_range    = (addr_i[31:AW+2] == BaseAddr[31:AW+2]) &&
                        (addr_i[31:2] != ErrAddr[31:2]);
   assign unused_addr = ^addr_i[1:0];

   // Grant decode: same-cycle in IDLE without wait states, otherwise at the end of the wait count.
   always_comb begin
      gnt_o = 1'b0;
      if (!rst_i && req_i && !stall_i) begin
         if (GntDelay == 0) begin
            gnt_o = (state_q == IDLE);
         end else begin
            gnt_o = (state_q == WAIT) && (cnt_q == '0);
         end
      end
   end

   // Grant FSM: IDLE starts a wait on each new request, WAIT counts down while not stalled.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_i && (GntDelay != 0)) begin
                  state_q <= WAIT;
                  cnt_q   <= CntInit;
               end
            end
            WAIT: begin
               if (!req_i || gnt_o) begin
                  state_q <= IDLE;
               end else if (!stall_i && (cnt_q != '0)) begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // RAM write port; contents deliberately survive reset.
   always_ff @(posedge clk_i) begin
      if (gnt_o && in_range && we_i) begin
         for (int k = 0; k < 4; k++) begin
            if (be_i[k]) begin
               mem_q[idx][8*k +: 8] <= wdata_i[8*k +: 8];
            end
         end
      end
   end

   // Response pipeline: stage 0 captures the granted access, later stages shift every cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < RespLatency; i++) begin
            valid_q[i] <= 1'b0;
            err_q[i]   <= 1'b0;
            rdata_q[i] <= '0;
         end
      end else begin
         valid_q[0] <= gnt_o;
         err_q[0]   <= gnt_o && !in_range;
         rdata_q[0] <= (gnt_o && in_range && !we_i) ? mem_q[idx] : '0;
         for (int i = 1; i < RespLatency; i++) begin
            valid_q[i] <= valid_q[i-1];
            err_q[i]   <= err_q[i-1];
            rdata_q[i] <= rdata_q[i-1];
         end
      end
   end

   assign rvalid_o = valid_q[RespLatency-1];
   assign err_o    = err_q[RespLatency-1];
   assign rdata_o  = rdata_q[RespLatency-1];

   // A pending request must hold its payload until granted.
   a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (req_i && !gnt_o) |=> $stable({addr_i, we_i, be_i, wdata_i}));

   // Dropping req_i during the wait is a protocol violation by the initiator.
   a_req_held: assert property (@(posedge clk_i) disable iff (rst_i)
      (state_q == WAIT) |-> req_i);

endmodule

// File: tb/tb_cve2_obi_mem_responder.sv
// tb/tb_cve2_obi_mem_responder.sv - scoreboard bench for cve2_obi_mem_responder
module tb_cve2_obi_mem_responder;

   localparam int NI = 3;
   localparam int MW = 64;

   typedef struct {
      int          inst;
      int          due;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, stall, req_c, we;
   logic [31:0] addr, wdata;
   logic [3:0]  be;
   int          sel;
   logic        req    [NI];
   logic        gnt    [NI];
   logic        rvalid [NI];
   logic [31:0] rdata  [NI];
   logic        err    [NI];

   int          cyc    = 0;
   int          n_chk  = 0;
   int          n_fail = 0;
   bit          mon_en = 1'b0;
   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [31:0] mdl [int];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign req[0] = req_c && (sel == 0);
   assign req[1] = req_c && (sel == 1);
   assign req[2] = req_c && (sel == 2);

   cve2_obi_mem_responder #(.MemWords(MW), .BaseAddr(32'h0000_0000), .GntDelay(0),
      .RespLatency(1), .ErrAddr(32'h0000_0080)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr), .we_i(we),
      .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]),
      .stall_i(stall));
   cve2_obi_mem_responder #(.MemWords(MW), .BaseAddr(32'h1000_0000), .GntDelay(3),
      .RespLatency(2), .ErrAddr(32'hFFFF_FFFC)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr), .we_i(we),
      .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]),
      .stall_i(stall));
   cve2_obi_mem_responder #(.MemWords(MW), .BaseAddr(32'h2000_0000), .GntDelay(0),
      .RespLatency(3), .ErrAddr(32'hFFFF_FFFC)) u_dut2 (
      .clk_i(clk), .rst_i(rst), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr), .we_i(we),
      .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .err_o(err[2]),
      .stall_i(stall));

   function automatic int gd(int k);
      return (k == 1) ? 3 : 0;
   endfunction

   function automatic int lat(int k);
      case (k)
         0:       return 1;
         1:       return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic [31:0] base(int k);
      case (k)
         0:       return 32'h0000_0000;
         1:       return 32'h1000_0000;
         default: return 32'h2000_0000;
      endcase
   endfunction

   function automatic logic [31:0] erra(int k);
      return (k == 0) ? 32'h0000_0080 : 32'hFFFF_FFFC;
   endfunction

   function automatic bit model_in_range(int k, logic [31:0] a);
      logic [31:0] off;
      logic [31:0] e;
      off = a - base(k);
      e   = erra(k);
      return (a >= base(k)) && ((off >> 2) < 32'(MW)) && ((a >> 2) != (e >> 2));
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Monitor: every response is matched against the head of the scoreboard.
   always @(negedge clk) begin
      if (mon_en) begin
         for (int k = 0; k < NI; k++) begin
            if (rvalid[k] === 1'b1) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_rvalid", 32'(k), 32'hFFFF_FFFF);
               end else begin
                  mon_e = exp_q.pop_front();
                  chk("resp_inst",  32'(k),      32'(mon_e.inst));
                  chk("resp_cycle", 32'(cyc),    32'(mon_e.due));
                  chk("resp_err",   32'(err[k]), 32'(mon_e.err));
                  chk("resp_rdata", rdata[k],    mon_e.rdata);
               end
            end else begin
               chk("idle_rvalid", 32'(rvalid[k]), 32'h0);
               chk("idle_rdata",  rdata[k],       32'h0);
               chk("idle_err",    32'(err[k]),    32'h0);
            end
         end
         if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            chk("missing_rvalid", 32'(cyc), 32'(exp_q[0].due));
            void'(exp_q.pop_front());
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 of the cycle after the grant with req still high.
   task automatic issue(int k, logic w, logic [31:0] a, logic [3:0] b, logic [31:0] d, int nstall);
      int          start;
      int          g;
      int          key;
      bit          got;
      exp_t        e;
      logic [31:0] nw;
      sel   = k;
      req_c = 1'b1;
      we    = w;
      addr  = a;
      be    = b;
      wdata = d;
      stall = (nstall > 0);
      start = cyc;
      got   = 1'b0;
      g     = 0;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         if (gnt[k] === 1'b1) begin
            got = 1'b1;
            g   = cyc;
         end else begin
            @(posedge clk);
            #1;
            if (cyc - start >= nstall) stall = 1'b0;
         end
      end
      if (!got) begin
         chk("gnt_timeout", 32'h0, 32'h1);
         req_c = 1'b0;
         stall = 1'b0;
         @(posedge clk);
         #1;
         return;
      end
      chk("gnt_wait", 32'(g - start), 32'(gd(k) + nstall));
      e.inst = k;
      e.due  = g + lat(k);
      if (model_in_range(k, a)) begin
         key   = k * MW + int'((a - base(k)) >> 2);
         e.err = 1'b0;
         if (w) begin
            nw = mdl.exists(key) ? mdl[key] : 32'hxxxx_xxxx;
            for (int j = 0; j < 4; j++) if (b[j]) nw[8*j +: 8] = d[8*j +: 8];
            mdl[key] = nw;
            e.rdata  = 32'h0;
         end else begin
            e.rdata = mdl.exists(key) ? mdl[key] : 32'hxxxx_xxxx;
         end
      end else begin
         e.err   = 1'b1;
         e.rdata = 32'h0;
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(int n);
      req_c = 1'b0;
      stall = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int          k;
      int          lastk;
      int          r;
      logic [31:0] a;

      rst = 1'b1; stall = 1'b0; req_c = 1'b1; sel = 0;
      addr = 32'h10; we = 1'b0; be = 4'hF; wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         chk("rst_gnt",    32'(gnt[i]),    32'h0);
         chk("rst_rvalid", 32'(rvalid[i]), 32'h0);
         chk("rst_rdata",  rdata[i],       32'h0);
         chk("rst_err",    32'(err[i]),    32'h0);
      end
      @(posedge clk);
      #1;
      req_c  = 1'b0;
      rst    = 1'b0;
      mon_en = 1'b1;
      idle(1);

      // Fill a known window of each RAM.
      for (int i = 0; i < NI; i++) begin
         for (int j = 0; j < 16; j++) issue(i, 1'b1, base(i) + 32'(4 * j), 4'hF, $urandom, 0);
         idle(4);
      end

      // Basic write then read, same-cycle grant.
      issue(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 0);
      issue(0, 1'b0, 32'h10, 4'hF, 32'h0, 0);
      idle(1);
      chk("model_word4", mdl[4], 32'hDEADBEEF);

      // Partial byte enables and an empty-mask write.
      issue(0, 1'b1, 32'h20, 4'hF, 32'hFFFFFFFF, 0);
      issue(0, 1'b1, 32'h20, 4'b0101, 32'h11223344, 0);
      issue(0, 1'b1, 32'h20, 4'b0000, 32'h00000000, 0);
      issue(0, 1'b0, 32'h20, 4'hF, 32'h0, 0);
      idle(1);
      chk("model_word8", mdl[8], 32'hFF22FF44);

      // Out-of-range and injected error addresses; word 0 must be untouched.
      issue(0, 1'b0, 32'h100, 4'hF, 32'h0, 0);
      issue(0, 1'b1, 32'h100, 4'hF, 32'hA5A5A5A5, 0);
      issue(0, 1'b1, 32'h80, 4'hF, 32'h5A5A5A5A, 0);
      issue(0, 1'b0, 32'h80, 4'hF, 32'h0, 0);
      issue(0, 1'b0, 32'h0, 4'hF, 32'h0, 0);
      idle(1);

      // Backpressure for five cycles.
      issue(0, 1'b0, 32'h14, 4'hF, 32'h0, 5);
      idle(4);

      // Wait states with req held across back-to-back reads.
      for (int j = 0; j < 4; j++) issue(1, 1'b0, 32'h1000_0000 + 32'(4 * j), 4'hF, 32'h0, 0);
      idle(4);

      // Reset with two reads in flight.
      issue(2, 1'b0, 32'h2000_0000, 4'hF, 32'h0, 0);
      issue(2, 1'b0, 32'h2000_0004, 4'hF, 32'h0, 0);
      req_c = 1'b0;
      rst   = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk("midrst_rvalid", 32'(rvalid[2]), 32'h0);
      chk("midrst_rdata",  rdata[2],       32'h0);
      chk("midrst_gnt",    32'(gnt[2]),    32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(4);
      issue(2, 1'b0, 32'h2000_0008, 4'hF, 32'h0, 0);
      idle(4);

      // Randomised mix across all three configurations.
      lastk = 2;
      for (int n = 0; n < 150; n++) begin
         k = $urandom_range(0, 2);
         if (k != lastk) idle(4);
         else if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         lastk = k;
         r = $urandom_range(0, 9);
         if (r == 0)      a = base(k) + 32'(MW * 4) + 32'(4 * $urandom_range(0, 31));
         else if (r == 1) a = base(k) - 32'h4;
         else             a = base(k) + 32'(4 * $urandom_range(0, 15));
         a[1:0] = 2'($urandom_range(0, 3));
         issue(k, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom,
               (k == 0) ? $urandom_range(0, 2) : 0);
      end
      idle(4);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
